booths_multiplier_seq: RTL
==========================

Name: booths_multiplier_seq

Overview:
Iterative, parametrised radix-2 Booth multiplier for signed two's-complement operands of WIDTH bits. It performs one Booth add/subtract-and-shift step per clock instead of a combinational cascade. A start/busy/done handshake lets a controller or datapath FSM issue back-to-back multiplies. It is the sequential, width-generic successor to the 4-bit unrolled Booth multiplier.

Parameters:
- WIDTH, default 8: operand width in bits, signed two's complement; legal values are 2 to 32. The product is 2*WIDTH bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled on a clk edge only when the block is not busy.
- m  input  WIDTH  multiplicand, signed; sampled at the accepted start edge only.
- q  input  WIDTH  multiplier, signed; sampled at the accepted start edge only.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; z is valid in that cycle.
- z  output  2*WIDTH  signed product; held until the next completion or reset.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; busy=0; done=0; z=0; internal A, Q, Q_-1, M and count cleared. Reset has priority over every other input, including mid-operation; a partial result is discarded and done is not pulsed.
- Internal registers:
  - A: WIDTH+1 bits. The extra guard bit makes A-M exact for m = -2^(WIDTH-1).
  - M: WIDTH+1 bits, sign-extended copy of m.
  - Q: WIDTH bits.
  - Q_-1: 1 bit.
  - count: ceil(log2(WIDTH+1)) bits.
- States:
  - IDLE: busy=0. On start=1, load A=0, M=sext(m), Q=q, Q_-1=0, count=WIDTH, and go to RUN.
  - RUN: busy=1. Each clk performs one step:
    - {Q[0],Q_-1}=01: A=A+M.
    - {Q[0],Q_-1}=10: A=A-M.
    - 00 or 11: A unchanged.
    - Then arithmetic-shift-right {A,Q,Q_-1} by 1, preserving A's MSB.
    - count decrements by 1.
    - On the step where count goes 1 -> 0: z <= {A[WIDTH-1:0],Q} taken from the post-shift values, done=1 next cycle, state goes to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 here is accepted (back-to-back): reload as in IDLE and go to RUN.
    - Otherwise go to IDLE.
- Latency: start accepted at edge k; steps run at edges k+1 .. k+WIDTH; done=1 and z valid in the cycle after edge k+WIDTH. Throughput is one product per WIDTH+1 cycles.
- start while busy=1 is ignored. m and q may change freely after acceptance without affecting the result.
- Arithmetic is exact for all operand pairs, including (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2). No overflow or saturation is possible.
- z keeps its last value through IDLE and across ignored starts; only a completion or reset updates it.
- done is never asserted in two consecutive cycles.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=4: m=3, q=-5 -> done exactly 4 cycles after the start edge; z=8'hF1 (-15); busy high for 4 cycles.
- WIDTH=4: m=-8, q=-8 -> z=8'h40 (+64); checks the guard bit. Then m=-8, q=7 -> z=8'hC8 (-56).
- WIDTH=8: m=-128, q=-128 -> z=16'h4000. Then start asserted during the DONE cycle with m=127, q=-128 -> second done 8 cycles later; z=16'hC080 (-16256); first z held until then.
- WIDTH=8: m=25, q=-3, then start re-pulsed with m=1, q=1 at mid-run cycle 3 -> ignored; z=16'hFFB5 (-75); single done pulse.
- WIDTH=8: rst asserted at step 4 of m=100, q=100 -> next cycle busy=0, done=0, z=0, state IDLE; a subsequent m=100, q=100 yields z=16'h2710.
- WIDTH=4 and WIDTH=8: random or exhaustive operand sweep against a signed reference model; every z matches, and done spacing is always at least WIDTH+1 cycles.

Source files
------------

// File: rtl/booths_multiplier_seq_if.sv
// Start/busy/done handshake and operand/product bus for the sequential Booth multiplier.
interface booths_multiplier_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;

  modport master (output start, output m, output q, input busy, input done, input z);
  modport slave  (input start, input m, input q, output busy, output done, output z);
endinterface

// File: rtl/booths_multiplier_seq.sv
// Iterative radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// signed WIDTH x WIDTH -> 2*WIDTH product with a start/busy/done handshake.
module booths_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booths_multiplier_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic                 load;
  logic                 last_step;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH-1:0]     q_sh;
  logic                 busy_o, done_o;

  // A new multiply is accepted whenever no step is in flight (IDLE or DONE).
  assign load      = bus.start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (count_q == CW'(1));

  // State register
  // NOTE: every register here, datapath included, is reset so z reads 0 after rst
  // and no stale partial product survives an aborted run.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // registers update together from the values present before the edge.
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default before the case keeps this combinational; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (count_q == CW'(1)) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth step: recode {Q[0],Q_-1}, then arithmetic shift of {A,Q,Q_-1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    z_d     = z_q;
    if (load) begin
      a_d     = '0;
      m_d     = {bus.m[WIDTH-1], bus.m};
      q_d     = bus.q;
      qm1_d   = 1'b0;
      count_d = CW'(WIDTH);
    end else if (state_q == RUN) begin
      a_d     = a_sh;
      q_d     = q_sh;
      qm1_d   = q_q[0];
      count_d = count_q - CW'(1);
    end
    // The guard bit of A is dropped only here; the product fits in 2*WIDTH bits.
    if (last_step) z_d = {a_sh[WIDTH-1:0], q_sh};
  end

  // Output logic: decoded from the state register only, so no input-to-output path.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      RUN:     busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.z    = z_q;

endmodule
